// File: rtl/ipgu_pyramid_scanner.sv
// rtl/ipgu_pyramid_scanner.sv - streams WIN x WIN windows of a nearest-neighbour pyramid, one row per beat
// Optional IPGU_PERF_CNT_EN adds win_count/stall_cycles ports.
module ipgu_pyramid_scanner #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 300,
  parameter int IMG_H      = 300,
  parameter int WIN        = 20,
  parameter int STRIDE     = 20,
  parameter int LEVELS     = 4,
  parameter int STEP_Q     = 320
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_en,
  output logic [$clog2(IMG_W*IMG_H)-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [WIN*DATA_WIDTH-1:0]       out_row,
  output logic                            out_sow,
  output logic                            out_eow,
  output logic [$clog2(LEVELS+1)-1:0]     out_level,
  output logic [$clog2(IMG_W)-1:0]        out_ox,
  output logic [$clog2(IMG_H)-1:0]        out_oy
`ifdef IPGU_PERF_CNT_EN
  ,
  output logic [31:0]                     win_count,
  output logic [31:0]                     stall_cycles
`endif
);

  localparam int AW = $clog2(IMG_W*IMG_H);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int LW = $clog2(LEVELS+1);
  localparam int CW = $clog2(WIN+1);
  localparam logic L0_FITS = (WIN <= IMG_W) && (WIN <= IMG_H);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_NEXT} state_t;

  function automatic logic [47:0] scale(input logic [47:0] c, input logic [15:0] s);
    return (c * {32'd0, s}) >> 8;
  endfunction

  function automatic logic fits(input logic [47:0] o, input logic [15:0] s, input int lim);
    return scale(o + 48'(WIN - 1), s) <= 48'(lim - 1);
  endfunction

  function automatic logic [AW-1:0] pix_addr(input logic [47:0] x, input logic [47:0] y,
                                             input logic [15:0] s);
    return AW'(scale(y, s) * 48'(IMG_W) + scale(x, s));
  endfunction

  function automatic logic [15:0] next_step(input logic [15:0] s);
    logic [47:0] p;
    p = ({32'd0, s} * 48'(STEP_Q)) >> 8;
    return (p > 48'hFFFF) ? 16'hFFFF : 16'(p);
  endfunction

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  logic [CW-1:0]           col_q, col_d, row_q, row_d, pend_col_q, pend_col_d;
  logic                    pend_q, pend_d;
  logic [XW-1:0]           ox_q, ox_d, out_ox_q, out_ox_d;
  logic [YW-1:0]           oy_q, oy_d, out_oy_q, out_oy_d;
  logic [LW-1:0]           lvl_q, lvl_d, out_level_q, out_level_d;
  logic [15:0]             step_q, step_d, ns;
  logic                    out_vld_q, out_vld_d, out_sow_q, out_sow_d, out_eow_q, out_eow_d;
  logic [WIN*DATA_WIDTH-1:0] out_row_q, out_row_d;
  logic [47:0]             nx, ny;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    col_d       = col_q;
    row_d       = row_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    lvl_d       = lvl_q;
    step_d      = step_q;
    out_vld_d   = out_vld_q;
    out_row_d   = out_row_q;
    out_sow_d   = out_sow_q;
    out_eow_d   = out_eow_q;
    out_level_d = out_level_q;
    out_ox_d    = out_ox_q;
    out_oy_d    = out_oy_q;
    pend_d      = rd_en_q;
    pend_col_d  = col_q;
    nx          = 48'(ox_q) + 48'(STRIDE);
    ny          = 48'(oy_q) + 48'(STRIDE);
    ns          = next_step(step_q);

    // Read data lands one cycle after its strobe; slot it by the column that was addressed.
    if (pend_q) out_row_d[pend_col_q*DATA_WIDTH +: DATA_WIDTH] = rd_data;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          step_d = 16'd256;
          lvl_d  = '0;
          ox_d   = '0;
          oy_d   = '0;
          row_d  = '0;
          col_d  = '0;
          if (L0_FITS) begin
            busy_d    = 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            state_d   = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (32'(col_q) < WIN - 1) begin
          col_d     = col_q + 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = pix_addr(48'(ox_q) + 48'(col_q) + 48'd1, 48'(oy_q) + 48'(row_q), step_q);
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_vld_d   = 1'b1;
        out_sow_d   = (row_q == '0);
        out_eow_d   = (32'(row_q) == WIN - 1);
        out_level_d = lvl_q;
        out_ox_d    = ox_q;
        out_oy_d    = oy_q;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = S_NEXT;
          if (32'(row_q) < WIN - 1) begin
            row_d = row_q + 1'b1;
          end else begin
            row_d = '0;
            // Advance decided here so done can pulse the cycle right after the last transfer.
            if (fits(nx, step_q, IMG_W)) begin
              ox_d = XW'(nx);
            end else if (fits(ny, step_q, IMG_H)) begin
              ox_d = '0;
              oy_d = YW'(ny);
            end else if ((32'(lvl_q) + 1 < LEVELS) && fits(48'd0, ns, IMG_W) &&
                         fits(48'd0, ns, IMG_H)) begin
              lvl_d  = lvl_q + 1'b1;
              step_d = ns;
              ox_d   = '0;
              oy_d   = '0;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_NEXT: begin
        col_d     = '0;
        rd_en_d   = 1'b1;
        rd_addr_d = pix_addr(48'(ox_q), 48'(oy_q) + 48'(row_q), step_q);
        state_d   = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pend_q      <= 1'b0;
      pend_col_q  <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      lvl_q       <= '0;
      step_q      <= 16'd256;
      out_vld_q   <= 1'b0;
      out_row_q   <= '0;
      out_sow_q   <= 1'b0;
      out_eow_q   <= 1'b0;
      out_level_q <= '0;
      out_ox_q    <= '0;
      out_oy_q    <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pend_q      <= pend_d;
      pend_col_q  <= pend_col_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      lvl_q       <= lvl_d;
      step_q      <= step_d;
      out_vld_q   <= out_vld_d;
      out_row_q   <= out_row_d;
      out_sow_q   <= out_sow_d;
      out_eow_q   <= out_eow_d;
      out_level_q <= out_level_d;
      out_ox_q    <= out_ox_d;
      out_oy_q    <= out_oy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign out_vld   = out_vld_q;
  assign out_row   = out_row_q;
  assign out_sow   = out_sow_q;
  assign out_eow   = out_eow_q;
  assign out_level = out_level_q;
  assign out_ox    = out_ox_q;
  assign out_oy    = out_oy_q;

`ifdef IPGU_PERF_CNT_EN
  logic [31:0] win_count_q, win_count_d, stall_cycles_q, stall_cycles_d;

  always_comb begin
    win_count_d    = win_count_q;
    stall_cycles_d = stall_cycles_q;
    if (state_q == S_IDLE && start) begin
      win_count_d    = '0;
      stall_cycles_d = '0;
    end else begin
      if (out_vld_q && out_rdy && out_eow_q && win_count_q != 32'hFFFF_FFFF)
        win_count_d = win_count_q + 32'd1;
      if (out_vld_q && !out_rdy && stall_cycles_q != 32'hFFFF_FFFF)
        stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_count_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      win_count_q    <= win_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign win_count    = win_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule
